// File: rtl/scale_ctrl.sv
// scale_ctrl: job controller for a vector scaling datapath.
//
// Holds a per-group parameter table {mul, n, relu}. It issues accumulator
// vectors to an external scaling datapath with a fixed latency and collects
// the results into a credit-limited FWFT output FIFO.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_we/addr/mul/n/relu     parameter table write port (accepted in IDLE only)
//   cfg_ngrp, cfg_total        job shape, latched on start
//   start, abort               job control pulses
//   busy, done, err_unexp      job status (done is a one-cycle pulse, err is sticky)
//   acc_data/valid/ready       accumulator vector input
//   sc_data1/valid1, sc_data2,
//   sc_n, sc_relu              registered operands towards the datapath
//   sc_sdata, sc_svalid        datapath results
//   out_data/valid/ready       output vector stream
//   dbg_state                  current FSM state (0 IDLE, 1 RUN, 2 FIN, 3 FLUSH)
//
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high at the rising clock edge. A source must hold valid and data stable
// until it is accepted. acc_ready depends only on registered state, so it
// never depends on acc_valid.
module scale_ctrl #(
    parameter int DN   = 6,
    parameter int DW   = 22,
    parameter int MULW = 9,
    parameter int OW   = 8,
    parameter int AW   = 6,
    parameter int CRED = 8,
    parameter int LAT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [DN*MULW-1:0] cfg_mul,
    input  logic [4:0]         cfg_n,
    input  logic [1:0]         cfg_relu,
    input  logic [AW-1:0]      cfg_ngrp,
    input  logic [15:0]        cfg_total,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err_unexp,
    input  logic [DN*DW-1:0]   acc_data,
    input  logic               acc_valid,
    output logic               acc_ready,
    output logic [DN*DW-1:0]   sc_data1,
    output logic               sc_valid1,
    output logic [DN*MULW-1:0] sc_data2,
    output logic [4:0]         sc_n,
    output logic [1:0]         sc_relu,
    input  logic [DN*OW-1:0]   sc_sdata,
    input  logic               sc_svalid,
    output logic [DN*OW-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         dbg_state
);

    localparam int TEW = DN*MULW + 7;
    localparam int PW  = (CRED > 1) ? $clog2(CRED) : 1;
    localparam int CW  = $clog2(CRED + 1);
    localparam logic [CW:0]   CRED_W  = (CW+1)'(CRED);
    localparam logic [PW-1:0] PTR_MAX = PW'(CRED - 1);

    // The datapath latency is a property of the external pipeline. Credits
    // cover it, so only its sanity is checked here.
    if (LAT < 1 || CRED < 1) begin : g_bad_param
        $error("scale_ctrl: LAT and CRED must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2, S_FLUSH = 2'd3} state_t;

    state_t               state_q;
    logic                 busy_q, done_q, err_q;
    logic                 sc_valid1_q;
    logic [DN*DW-1:0]     sc_data1_q;
    logic [DN*MULW-1:0]   sc_data2_q;
    logic [4:0]           sc_n_q;
    logic [1:0]           sc_relu_q;
    logic [15:0]          total_q, issued_q, issued_d;
    logic [AW-1:0]        ngrp_q, grp_q, grp_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW:0]          credit_used;
    logic                 issue, ret, push, pop, flush_entry;

    logic [TEW-1:0]       tbl_q [2**AW];
    logic [DN*OW-1:0]     fifo_mem [CRED];

    // Credits count both results still in the datapath and results parked
    // in the FIFO, so a returning result always has a free FIFO slot.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign acc_ready   = (state_q == S_RUN) && (issued_q < total_q) && (credit_used < CRED_W);
    assign issue       = acc_valid && acc_ready;
    // A result is only legitimate when something is outstanding.
    assign ret         = sc_svalid && (inflight_q != '0);
    assign push        = ret && !abort && ((state_q == S_RUN) || (state_q == S_FIN));
    assign out_valid   = (fifo_cnt_q != '0);
    assign out_data    = fifo_mem[rd_ptr_q];
    assign pop         = out_valid && out_ready;
    assign flush_entry = abort && (state_q != S_IDLE);

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !ret) inflight_d = inflight_q + 1'b1;
        else if (!issue && ret) inflight_d = inflight_q - 1'b1;

        issued_d = issue ? issued_q + 16'd1 : issued_q;
        grp_d    = grp_q;
        if (issue) grp_d = (grp_q == ngrp_q) ? '0 : grp_q + 1'b1;

        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop) fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
        // Entering FLUSH throws away every buffered result.
        if (flush_entry) begin
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    // Table and FIFO storage carry no reset.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == S_IDLE) tbl_q[cfg_addr] <= {cfg_mul, cfg_n, cfg_relu};
        if (push) fifo_mem[wr_ptr_q] <= sc_sdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sc_valid1_q <= 1'b0;
            sc_data1_q  <= '0;
            sc_data2_q  <= '0;
            sc_n_q      <= '0;
            sc_relu_q   <= '0;
            total_q     <= '0;
            ngrp_q      <= '0;
            issued_q    <= '0;
            grp_q       <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            done_q      <= 1'b0;
            sc_valid1_q <= issue;
            if (issue) begin
                sc_data1_q                       <= acc_data;
                {sc_data2_q, sc_n_q, sc_relu_q}  <= tbl_q[grp_q];
            end
            if (sc_svalid && inflight_q == '0) err_q <= 1'b1;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            issued_q   <= issued_d;
            grp_q      <= grp_d;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        total_q  <= cfg_total;
                        ngrp_q   <= cfg_ngrp;
                        issued_q <= '0;
                        grp_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= (cfg_total == 16'd0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) state_q <= S_FLUSH;
                    else if (issued_d == total_q) state_q <= S_FIN;
                end
                S_FIN: begin
                    if (abort) begin
                        state_q <= S_FLUSH;
                    end else if (inflight_q == '0 && fifo_cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (!abort && inflight_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_unexp = err_q;
    assign sc_valid1 = sc_valid1_q;
    assign sc_data1  = sc_data1_q;
    assign sc_data2  = sc_data2_q;
    assign sc_n      = sc_n_q;
    assign sc_relu   = sc_relu_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_scale_ctrl.sv
// Testbench for scale_ctrl: directed jobs against a fixed-latency datapath
// model, with issue and output scoreboards checked by a monitor process.
module tb_scale_ctrl;

    localparam int DN = 6, DW = 22, MULW = 9, OW = 8, AW = 6, CRED = 8, LAT = 4;
    localparam int TEW = DN*MULW + 7;

    logic               clk = 1'b0, rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [AW-1:0]      cfg_addr = '0, cfg_ngrp = '0;
    logic [DN*MULW-1:0] cfg_mul = '0;
    logic [4:0]         cfg_n = '0;
    logic [1:0]         cfg_relu = '0;
    logic [15:0]        cfg_total = '0;
    logic               start = 1'b0, abort = 1'b0;
    logic               busy, done, err_unexp;
    logic [DN*DW-1:0]   acc_data = '0;
    logic               acc_valid = 1'b0, acc_ready;
    logic [DN*DW-1:0]   sc_data1;
    logic               sc_valid1;
    logic [DN*MULW-1:0] sc_data2;
    logic [4:0]         sc_n;
    logic [1:0]         sc_relu;
    logic [DN*OW-1:0]   sc_sdata;
    logic               sc_svalid;
    logic [DN*OW-1:0]   out_data;
    logic               out_valid, out_ready = 1'b1;
    logic [1:0]         dbg_state;

    scale_ctrl #(.DN(DN), .DW(DW), .MULW(MULW), .OW(OW), .AW(AW), .CRED(CRED), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mul(cfg_mul),
        .cfg_n(cfg_n), .cfg_relu(cfg_relu), .cfg_ngrp(cfg_ngrp), .cfg_total(cfg_total),
        .start(start), .abort(abort), .busy(busy), .done(done), .err_unexp(err_unexp),
        .acc_data(acc_data), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .sc_data1(sc_data1), .sc_valid1(sc_valid1), .sc_data2(sc_data2), .sc_n(sc_n),
        .sc_relu(sc_relu), .sc_sdata(sc_sdata), .sc_svalid(sc_svalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int iss_cnt = 0, done_cnt = 0;
    logic prev_busy = 1'b0;
    logic [TEW-1:0]     tbl_m [4];
    logic [DN*DW-1:0]   exp_d1_q [$];
    logic [TEW-1:0]     exp_par_q [$];
    logic [DN*OW-1:0]   exp_out_q [$];

    // ---------------- helpers ----------------
    function automatic logic [DN*DW-1:0] mk_vec(input int k);
        logic [DN*DW-1:0] v;
        for (int i = 0; i < DN; i++) v[i*DW +: DW] = DW'(k*8 + i*3 + 1);
        return v;
    endfunction

    function automatic logic [DN*MULW-1:0] mk_mul(input int g);
        logic [DN*MULW-1:0] m;
        for (int i = 0; i < DN; i++) m[i*MULW +: MULW] = MULW'(g*10 + i + 3);
        return m;
    endfunction

    // Stand-in datapath result: per lane, low accumulator byte plus low multiplier byte.
    function automatic logic [DN*OW-1:0] lane_fn(input logic [DN*DW-1:0] a, input logic [DN*MULW-1:0] m);
        logic [DN*OW-1:0] r;
        for (int i = 0; i < DN; i++) r[i*OW +: OW] = a[i*DW +: OW] + m[i*MULW +: OW];
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- datapath model (fixed latency LAT) ----------------
    logic [LAT-1:0]   pipe_v = '0;
    logic [DN*OW-1:0] pipe_d [LAT];
    logic             inj_v = 1'b0;

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[LAT-2:0], sc_valid1};
        pipe_d[0] <= lane_fn(sc_data1, sc_data2);
        for (int k = 1; k < LAT; k++) pipe_d[k] <= pipe_d[k-1];
    end
    assign sc_svalid = pipe_v[LAT-1] | inj_v;
    assign sc_sdata  = inj_v ? {(DN*OW){1'b1}} : pipe_d[LAT-1];

    // ---------------- driver tasks (entered at posedge + 1) ----------------
    task automatic push_job(input int n, input int base, input int ngrp, input bit with_out);
        for (int k = 0; k < n; k++) begin
            int g;
            g = k % (ngrp + 1);
            exp_d1_q.push_back(mk_vec(base + k));
            exp_par_q.push_back(tbl_m[g]);
            if (with_out) exp_out_q.push_back(lane_fn(mk_vec(base + k), tbl_m[g][TEW-1:7]));
        end
    endtask

    task automatic start_job(input int total, input int ngrp);
        cfg_total = 16'(total);
        cfg_ngrp  = AW'(ngrp);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_acc(input int n, input int base, input int budget);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < budget) begin
            acc_valid = 1'b1;
            acc_data  = mk_vec(base + k);
            @(negedge clk);
            if (acc_ready) k++;
            @(posedge clk); #1;
            cyc++;
        end
        acc_valid = 1'b0;
        check("acc_handshakes", 256'(k), 256'(n));
    endtask

    task automatic wait_idle(input int budget);
        int cyc = 0;
        @(negedge clk);
        while (busy && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_within_budget", 256'(busy), 256'(0));
        @(posedge clk); #1;
    endtask

    task automatic clear_queues();
        exp_d1_q.delete();
        exp_par_q.delete();
        exp_out_q.delete();
    endtask

    // ---------------- main sequence + monitor ----------------
    initial begin
        int d0, i0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (sc_valid1) begin
                        iss_cnt++;
                        if (exp_d1_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL iss_unexpected: got issue %0h, required no issue", sc_data1);
                        end else begin
                            check("iss_data1", 256'(sc_data1), 256'(exp_d1_q.pop_front()));
                            check("iss_param", 256'({sc_data2, sc_n, sc_relu}), 256'(exp_par_q.pop_front()));
                        end
                    end
                    if (out_valid && out_ready) begin
                        if (exp_out_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL out_unexpected: got output %0h, required no output", out_data);
                        end else begin
                            check("out_data", 256'(out_data), 256'(exp_out_q.pop_front()));
                        end
                    end
                    if (done) begin
                        done_cnt++;
                        check("busy_falls_with_done", 256'({prev_busy, busy}), 256'(2'b10));
                    end
                    prev_busy = busy;
                end
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_err", 256'(err_unexp), 256'(0));
        check("rst_acc_ready", 256'(acc_ready), 256'(0));
        check("rst_sc_valid1", 256'(sc_valid1), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_sc_data1", 256'(sc_data1), 256'(0));
        check("rst_sc_data2", 256'(sc_data2), 256'(0));
        check("rst_sc_n", 256'(sc_n), 256'(0));
        check("rst_sc_relu", 256'(sc_relu), 256'(0));
        check("rst_state", 256'(dbg_state), 256'(0));

        // Load table groups 0..3 in IDLE
        for (int g = 0; g < 4; g++) begin
            tbl_m[g] = {mk_mul(g), 5'(g + 1), 2'(g)};
            cfg_we = 1'b1; cfg_addr = AW'(g);
            cfg_mul = mk_mul(g); cfg_n = 5'(g + 1); cfg_relu = 2'(g);
            @(posedge clk); #1;
        end
        cfg_we = 1'b0;

        // Basic job: 3 groups, 6 vectors
        d0 = done_cnt; i0 = iss_cnt;
        push_job(6, 0, 2, 1'b1);
        start_job(6, 2);
        check("basic_busy", 256'(busy), 256'(1));
        drive_acc(6, 0, 100);
        wait_idle(100);
        repeat (5) @(posedge clk); #1;
        check("basic_done_once", 256'(done_cnt - d0), 256'(1));
        check("basic_issues", 256'(iss_cnt - i0), 256'(6));
        check("basic_out_drained", 256'(exp_out_q.size()), 256'(0));

        // Empty job: done two cycles after start, nothing issued
        d0 = done_cnt; i0 = iss_cnt;
        start_job(0, 0);
        check("empty_fin_busy", 256'(busy), 256'(1));
        check("empty_no_done_yet", 256'(done), 256'(0));
        @(posedge clk); #1;
        check("empty_done", 256'(done), 256'(1));
        @(posedge clk); #1;
        check("empty_done_one_cycle", 256'(done), 256'(0));
        repeat (3) @(posedge clk); #1;
        check("empty_no_issue", 256'(iss_cnt - i0), 256'(0));
        check("empty_done_count", 256'(done_cnt - d0), 256'(1));

        // Backpressure: credits stop issue at CRED
        i0 = iss_cnt;
        out_ready = 1'b0;
        push_job(20, 40, 3, 1'b1);
        start_job(20, 3);
        fork
            drive_acc(20, 40, 300);
            begin
                repeat (30) @(posedge clk); #1;
                check("bp_issues_at_credit", 256'(iss_cnt - i0), 256'(CRED));
                check("bp_acc_ready_low", 256'(acc_ready), 256'(0));
                check("bp_out_valid", 256'(out_valid), 256'(1));
                out_ready = 1'b1;
            end
        join
        wait_idle(200);
        check("bp_issues_total", 256'(iss_cnt - i0), 256'(20));
        check("bp_out_drained", 256'(exp_out_q.size()), 256'(0));

        // Config gating: table writes during RUN are ignored
        push_job(4, 80, 0, 1'b1);
        start_job(4, 0);
        fork
            drive_acc(4, 80, 100);
            begin
                @(posedge clk); #1;
                cfg_we = 1'b1; cfg_addr = '0; cfg_mul = mk_mul(7); cfg_n = 5'd31; cfg_relu = 2'd3;
                @(posedge clk); #1;
                cfg_we = 1'b0;
            end
        join
        wait_idle(100);
        check("gate_par_drained", 256'(exp_par_q.size()), 256'(0));

        // Abort with three in flight
        d0 = done_cnt;
        push_job(3, 120, 2, 1'b0);
        start_job(10, 2);
        drive_acc(3, 120, 50);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_state_flush", 256'(dbg_state), 256'(3));
        check("abort_busy", 256'(busy), 256'(1));
        check("abort_acc_ready", 256'(acc_ready), 256'(0));
        wait_idle(50);
        repeat (3) @(posedge clk); #1;
        check("abort_no_done", 256'(done_cnt - d0), 256'(0));
        check("abort_out_valid", 256'(out_valid), 256'(0));
        check("abort_err_clear", 256'(err_unexp), 256'(0));
        check("abort_iss_drained", 256'(exp_d1_q.size()), 256'(0));

        // Subsequent job runs normally
        d0 = done_cnt;
        push_job(3, 200, 1, 1'b1);
        start_job(3, 1);
        drive_acc(3, 200, 50);
        wait_idle(50);
        check("post_abort_done", 256'(done_cnt - d0), 256'(1));
        check("post_abort_out_drained", 256'(exp_out_q.size()), 256'(0));

        // Unexpected return in IDLE: sticky until reset
        inj_v = 1'b1;
        @(posedge clk); #1;
        inj_v = 1'b0;
        check("unexp_err_set", 256'(err_unexp), 256'(1));
        check("unexp_no_output", 256'(out_valid), 256'(0));
        repeat (5) @(posedge clk); #1;
        check("unexp_err_sticky", 256'(err_unexp), 256'(1));
        rst_n = 1'b0;
        #1;
        check("unexp_err_reset", 256'(err_unexp), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset mid-job: late results flag an error
        push_job(4, 300, 0, 1'b1);
        start_job(4, 0);
        drive_acc(2, 300, 20);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_sc_valid1", 256'(sc_valid1), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_queues();
        check("midrst_err_before_return", 256'(err_unexp), 256'(0));
        repeat (8) @(posedge clk); #1;
        check("midrst_err_late_return", 256'(err_unexp), 256'(1));
        check("midrst_state_idle", 256'(dbg_state), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
